// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and a
// constant-width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial input; both flops preset high on reset
// so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready output and
// parity/framing/overrun reporting. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a falling edge
// RX_START     | timing to mid start bit, rejecting glitches
// RX_DATA      | shifting in DATA_BITS data bits, LSB first
// RX_PARITY    | sampling the parity bit
// RX_STOP      | sampling STOP_BITS stop bits; frame completes on the last
// RX_WAIT_IDLE | line held low after the frame; wait for it to return high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int CW = clog2(OVERSAMPLE);
  localparam int BW = clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam logic [CW-1:0] CNT_START = CW'(OVERSAMPLE / 2 - 1 + MAJ);
  localparam logic [CW-1:0] CNT_BIT   = CW'(OVERSAMPLE - 1);

  rx_state_t state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_acc, ferr_acc;
  logic                 rxd_s, smp;
  logic cnt_clr, idx_clr, idx_inc, shift_en, par_en, stop_en, frame_clr, complete;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // The vote is taken one cycle late so the window straddles the nominal midpoint.
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rxd_s};
  end

  assign smp = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  assign smp = rxd_s;
`endif

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    frame_clr = 1'b0;
    complete  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (!rxd_s) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_START) begin
          cnt_clr = 1'b1;
          if (smp) begin
            state_nxt = RX_IDLE;
          end else begin
            state_nxt = RX_DATA;
            idx_clr   = 1'b1;
            frame_clr = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            idx_clr   = 1'b1;
            state_nxt = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (cnt == CNT_BIT) begin
          cnt_clr   = 1'b1;
          par_en    = 1'b1;
          state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_clr = 1'b1;
          stop_en = 1'b1;
          if (bit_idx == BW'(STOP_BITS - 1)) begin
            complete  = 1'b1;
            state_nxt = smp ? RX_IDLE : RX_WAIT_IDLE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rxd_s) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_clr ? '0 : cnt + CW'(1);
      if (idx_clr)      bit_idx <= '0;
      else if (idx_inc) bit_idx <= bit_idx + BW'(1);
      if (shift_en) shreg <= {smp, shreg[DATA_BITS-1:1]};
      if (frame_clr) begin
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (par_en) begin
        if (PARITY == PAR_ODD) perr_acc <= ~(^shreg ^ smp);
        else                   perr_acc <= ^shreg ^ smp;
      end
      if (stop_en && !smp) ferr_acc <= 1'b1;
    end
  end

  // A completing frame only replaces the held word if it is free or leaving now.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          rx_valid   <= 1'b1;
          parity_err <= perr_acc;
          frame_err  <= ferr_acc | ~smp;
        end else begin
          overrun_err <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and a 7E1 instance share
// one oversample clock; frames are driven bit by bit with hand-computed results.
module tb_uart_rx_param;

  localparam int OS = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 80;
`else
  localparam int LAT = 79;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1, rx_ready_a = 1'b1;
  logic       rxd_b = 1'b1, rx_ready_b = 1'b1;
  logic [7:0] rx_data_a;
  logic [6:0] rx_data_b;
  logic       rx_valid_a, parity_err_a, frame_err_a, overrun_a, busy_a;
  logic       rx_valid_b, parity_err_b, frame_err_b, overrun_b, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nrise_a = 0, rise_a = 0, novr_a = 0;
  int nrise_b = 0, rise_b = 0;
  logic [8:0] cap_data_a = '0, cap_data_b = '0;
  logic cap_perr_a = 0, cap_ferr_a = 0, cap_perr_b = 0, cap_ferr_b = 0;
  logic vq_a = 0, vq_b = 0;

  always #5 clk = ~clk;

  uart_rx_param u_dut_a (
    .clk (clk), .rst (rst), .rxd (rxd_a),
    .rx_data (rx_data_a), .rx_valid (rx_valid_a), .rx_ready (rx_ready_a),
    .parity_err (parity_err_a), .frame_err (frame_err_a),
    .overrun_err (overrun_a), .busy (busy_a)
  );

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .PARITY(2), .STOP_BITS(1)) u_dut_b (
    .clk (clk), .rst (rst), .rxd (rxd_b),
    .rx_data (rx_data_b), .rx_valid (rx_valid_b), .rx_ready (rx_ready_b),
    .parity_err (parity_err_b), .frame_err (frame_err_b),
    .overrun_err (overrun_b), .busy (busy_b)
  );

  // cyc numbers clock edges; rising rx_valid captures word and flags.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rx_valid_a && !vq_a) begin
      rise_a = cyc; nrise_a++;
      cap_data_a = 9'(rx_data_a); cap_perr_a = parity_err_a; cap_ferr_a = frame_err_a;
    end
    vq_a = rx_valid_a;
    if (overrun_a) novr_a++;
    if (rx_valid_b && !vq_b) begin
      rise_b = cyc; nrise_b++;
      cap_data_b = 9'(rx_data_b); cap_perr_b = parity_err_b; cap_ferr_b = frame_err_b;
    end
    vq_b = rx_valid_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v);
    set_line(sel, v);
    repeat (OS) @(posedge clk);
    #2;
  endtask

  // Called 2 time units after an edge; returns at the same phase. The line
  // is left at the stop value.
  task automatic send(input bit sel, input logic [8:0] d, input int nbits,
                      input bit has_par, input logic pbit, input logic stopv,
                      output int tfall);
    tfall = cyc;
    hold_bit(sel, 1'b0);
    for (int i = 0; i < nbits; i++) hold_bit(sel, d[i]);
    if (has_par) hold_bit(sel, pbit);
    hold_bit(sel, stopv);
  endtask

  initial begin
    int tf, tf2, n0, o0;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_valid", rx_valid_a, 1'b0);
    check("reset_busy", busy_a, 1'b0);
    check("reset_data", rx_data_a, 8'h00);
    check("reset_errs", {parity_err_a, frame_err_a, overrun_a}, 3'b000);
    repeat (4) @(posedge clk);
    #2;

    // 1: plain 8N1 frame
    n0 = nrise_a;
    send(0, 9'h0A5, 8, 0, 0, 1, tf);
    check("t1_count", nrise_a, n0 + 1);
    check("t1_latency", rise_a - tf, LAT);
    check("t1_data", cap_data_a, 9'h0A5);
    check("t1_errs", {cap_perr_a, cap_ferr_a}, 2'b00);
    check("t1_valid_one_cycle", rx_valid_a, 1'b0);
    repeat (5) @(posedge clk);
    #2;

    // 2: 7E1, 0x41 has two ones so the correct even parity bit is 0
    n0 = nrise_b;
    send(1, 9'h041, 7, 1, 1, 1, tf);
    check("t2_bad_count", nrise_b, n0 + 1);
    check("t2_bad_latency", rise_b - tf, LAT);
    check("t2_bad_data", cap_data_b, 9'h041);
    check("t2_bad_perr", cap_perr_b, 1'b1);
    check("t2_bad_ferr", cap_ferr_b, 1'b0);
    send(1, 9'h041, 7, 1, 0, 1, tf);
    check("t2_good_data", cap_data_b, 9'h041);
    check("t2_good_perr", cap_perr_b, 1'b0);

    // 3: 3-cycle glitch rejected
    n0 = nrise_a;
    rxd_a = 1'b0;
    repeat (3) @(posedge clk);
    #2 rxd_a = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    check("t3_glitch_novalid", nrise_a, n0);
    check("t3_glitch_busy", busy_a, 1'b0);
    send(0, 9'h03C, 8, 0, 0, 1, tf);
    check("t3_data", cap_data_a, 9'h03C);
    check("t3_count", nrise_a, n0 + 1);

    // 4: low stop bit, then break
    n0 = nrise_a;
    send(0, 9'h00F, 8, 0, 0, 0, tf);
    check("t4_latency", rise_a - tf, LAT);
    check("t4_data", cap_data_a, 9'h00F);
    check("t4_ferr", cap_ferr_a, 1'b1);
    repeat (40) @(posedge clk);
    #2;
    check("t4_wait_idle_busy", busy_a, 1'b1);
    check("t4_no_restart", nrise_a, n0 + 1);
    rxd_a = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("t4_idle_after_high", busy_a, 1'b0);
    send(0, 9'h05A, 8, 0, 0, 1, tf);
    check("t4_next_data", cap_data_a, 9'h05A);
    check("t4_next_ferr", cap_ferr_a, 1'b0);

    // 5: overrun with consumer stalled
    rx_ready_a = 1'b0;
    n0 = nrise_a;
    o0 = novr_a;
    send(0, 9'h011, 8, 0, 0, 1, tf);
    send(0, 9'h022, 8, 0, 0, 1, tf2);
    check("t5_rises", nrise_a, n0 + 1);
    check("t5_overrun_once", novr_a, o0 + 1);
    check("t5_data_kept", rx_data_a, 8'h11);
    check("t5_valid_held", rx_valid_a, 1'b1);
    rx_ready_a = 1'b1;
    @(posedge clk);
    #2;
    check("t5_valid_after_accept", rx_valid_a, 1'b0);
    repeat (5) @(posedge clk);
    #2;

    // 6: reset in the middle of the data bits
    n0 = nrise_a;
    fork
      send(0, 9'h0FF, 8, 0, 0, 1, tf);
      begin
        repeat (35) @(posedge clk);
        #2;
        check("t6_busy_before_rst", busy_a, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("t6_rst_busy", busy_a, 1'b0);
        check("t6_rst_data", rx_data_a, 8'h00);
        check("t6_rst_valid", rx_valid_a, 1'b0);
      end
    join
    repeat (10) @(posedge clk);
    #2;
    check("t6_no_valid", nrise_a, n0);
    send(0, 9'h081, 8, 0, 0, 1, tf);
    check("t6_next_data", cap_data_a, 9'h081);
    check("t6_next_latency", rise_a - tf, LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
